// File: rtl/freq_meter_multi.sv
// rtl/freq_meter_multi.sv - multi-channel gated frequency meter with synchronised inputs and saturation flags
module freq_meter_multi #(
    parameter int CHANNELS    = 4,
    parameter int GATE_CYCLES = 100000,
    parameter int SCALE       = 1000,
    parameter int CNT_W       = 20,
    parameter int FREQ_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       CLK100MHZ,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [1:0]                 edge_mode,
    input  logic [CHANNELS-1:0]        signal_in,
    output logic [CHANNELS*FREQ_W-1:0] freq_out,
    output logic [CHANNELS-1:0]        sat_out,
    output logic                       valid,
    output logic                       busy
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_GATE = 1'b1;

    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam int SUPP_W = $clog2(SYNC_STAGES + 2);
    localparam int PROD_W = CNT_W + $clog2(SCALE) + 1;
    localparam int EXT_W  = (PROD_W > FREQ_W) ? PROD_W : FREQ_W;

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [EXT_W-1:0]  FREQ_MAX  = EXT_W'({FREQ_W{1'b1}});

    logic [0:0]             state;
    logic [GATE_W-1:0]      gate_cnt;
    logic [1:0]             mode_q;
    logic [SUPP_W-1:0]      supp_q;
    logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
    logic [CHANNELS-1:0]    hist_q;
    logic [CNT_W-1:0]       cnt_q [CHANNELS];
    logic [CNT_W-1:0]       cnt_next [CHANNELS];
    logic [CHANNELS*FREQ_W-1:0] res_freq;
    logic [CHANNELS-1:0]    res_sat;

    // Synchroniser chains and edge history; supp_q masks the spurious edge a
    // high input would produce while the freshly cleared chain fills up.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= '0;
            end
            hist_q <= '0;
            supp_q <= SUPP_W'(SYNC_STAGES + 1);
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], signal_in[i]};
                hist_q[i] <= sync_q[i][SYNC_STAGES-1];
            end
            if (supp_q != '0) begin
                supp_q <= supp_q - SUPP_W'(1);
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic             synced;
        logic             hit;
        logic [CNT_W-1:0] cnt_nx;
        logic [EXT_W-1:0] prod;

        assign synced = sync_q[i][SYNC_STAGES-1];

        always_comb begin
            case (mode_q)
                2'b01:   hit = hist_q[i] & ~synced;
                2'b10:   hit = hist_q[i] ^ synced;
                default: hit = synced & ~hist_q[i];
            endcase
            if (supp_q != '0) begin
                hit = 1'b0;
            end
        end

        assign cnt_nx      = (hit && (cnt_q[i] != CNT_MAX)) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
        assign cnt_next[i] = cnt_nx;
        assign prod        = EXT_W'(PROD_W'(cnt_nx) * PROD_W'(SCALE));

        assign res_freq[i*FREQ_W +: FREQ_W] = (prod > FREQ_MAX) ? {FREQ_W{1'b1}} : prod[FREQ_W-1:0];
        assign res_sat[i] = (prod > FREQ_MAX) || (cnt_nx == CNT_MAX);
    end

    // Results are taken from cnt_next so an edge on the last window cycle is
    // included; the next window starts in the same cycle the result is stored.
    always_ff @(posedge CLK100MHZ) begin
        valid <= 1'b0;
        if (rst) begin
            state    <= S_IDLE;
            gate_cnt <= '0;
            mode_q   <= 2'b00;
            freq_out <= '0;
            sat_out  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    gate_cnt <= '0;
                    for (int i = 0; i < CHANNELS; i++) begin
                        cnt_q[i] <= '0;
                    end
                    if (enable) begin
                        state  <= S_GATE;
                        mode_q <= edge_mode;
                    end
                end
                default: begin
                    if (!enable) begin
                        state    <= S_IDLE;
                        gate_cnt <= '0;
                        for (int i = 0; i < CHANNELS; i++) begin
                            cnt_q[i] <= '0;
                        end
                    end else if (gate_cnt == GATE_LAST) begin
                        freq_out <= res_freq;
                        sat_out  <= res_sat;
                        valid    <= 1'b1;
                        gate_cnt <= '0;
                        mode_q   <= edge_mode;
                        for (int i = 0; i < CHANNELS; i++) begin
                            cnt_q[i] <= '0;
                        end
                    end else begin
                        gate_cnt <= gate_cnt + GATE_W'(1);
                        for (int i = 0; i < CHANNELS; i++) begin
                            cnt_q[i] <= cnt_next[i];
                        end
                    end
                end
            endcase
        end
    end

    assign busy = (state == S_GATE);

endmodule

// File: tb/tb_freq_meter_multi.sv
// tb/tb_freq_meter_multi.sv - randomized self-checking bench for freq_meter_multi
module tb_freq_meter_multi;
    localparam int CH    = 4;
    localparam int GATE  = 100;
    localparam int SCALE = 1000;
    localparam int FW    = 32;
    localparam int SYNC  = 2;
    localparam int MAXC  = 20000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic [1:0] edge_mode = 2'b00;
    logic [CH-1:0] signal_in = '0;
    logic [CH*FW-1:0] freq_out, freq_out4;
    logic [CH-1:0] sat_out, sat_out4;
    logic valid, valid4, busy, busy4;

    always #5 clk = ~clk;

    freq_meter_multi #(.CHANNELS(CH), .GATE_CYCLES(GATE), .SCALE(SCALE), .CNT_W(20),
                       .FREQ_W(FW), .SYNC_STAGES(SYNC)) dut (
        .CLK100MHZ(clk), .rst(rst), .enable(enable), .edge_mode(edge_mode),
        .signal_in(signal_in), .freq_out(freq_out), .sat_out(sat_out),
        .valid(valid), .busy(busy));

    freq_meter_multi #(.CHANNELS(CH), .GATE_CYCLES(GATE), .SCALE(SCALE), .CNT_W(4),
                       .FREQ_W(FW), .SYNC_STAGES(SYNC)) dut4 (
        .CLK100MHZ(clk), .rst(rst), .enable(enable), .edge_mode(edge_mode),
        .signal_in(signal_in), .freq_out(freq_out4), .sat_out(sat_out4),
        .valid(valid4), .busy(busy4));

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int dbl_cnt = 0;
    logic prev_valid = 1'b0;

    logic [CH-1:0] sig_rec [MAXC];
    logic [1:0]    mode_rec [MAXC];
    int gen_kind [CH];
    int period [CH];
    int phase [CH];
    logic [CH-1:0] hold_bits;
    logic [CH-1:0] sig;

    int            vq_cyc [$];
    logic [CH*FW-1:0] vq_f [$];
    logic [CH*FW-1:0] vq_f4 [$];
    logic [CH-1:0] vq_s [$];
    logic [CH-1:0] vq_s4 [$];

    // Edges on input recorded in cycle c (vs c-1) are seen SYNC cycles later.
    function automatic int exp_count(input int ch, input int first);
        int n = 0;
        logic [1:0] m;
        logic a, b;
        m = mode_rec[first-1];
        for (int d = first; d < first + GATE; d++) begin
            a = sig_rec[d-SYNC-1][ch];
            b = sig_rec[d-SYNC][ch];
            case (m)
                2'b01:   if (a && !b) n++;
                2'b10:   if (a != b) n++;
                default: if (!a && b) n++;
            endcase
        end
        return n;
    endfunction

    function automatic logic [31:0] exp_freq(input int n, input int cw);
        int lim;
        lim = (1 << cw) - 1;
        return 32'(((n > lim) ? lim : n) * SCALE);
    endfunction

    function automatic logic exp_sat(input int n, input int cw);
        return n >= ((1 << cw) - 1);
    endfunction

    task automatic tick();
        mode_rec[cyc] = edge_mode;
        @(posedge clk);
        #1;
        cyc++;
        if (valid) begin
            vq_cyc.push_back(cyc);
            vq_f.push_back(freq_out);
            vq_f4.push_back(freq_out4);
            vq_s.push_back(sat_out);
            vq_s4.push_back(sat_out4);
        end
        if (valid && prev_valid) dbl_cnt++;
        prev_valid = valid;
        for (int ch = 0; ch < CH; ch++) begin
            case (gen_kind[ch])
                1: sig[ch] = ((cyc + phase[ch]) % period[ch]) < (period[ch] / 2);
                2: if ($urandom_range(2) == 0) sig[ch] = ~sig[ch];
                default: sig[ch] = hold_bits[ch];
            endcase
        end
        signal_in = sig;
        sig_rec[cyc] = sig;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_q();
        vq_cyc.delete();
        vq_f.delete();
        vq_f4.delete();
        vq_s.delete();
        vq_s4.delete();
    endtask

    task automatic set_gen(input int ch, input int kind, input int p);
        gen_kind[ch] = kind;
        period[ch] = p;
        phase[ch] = int'($urandom_range(p - 1));
    endtask

    task automatic test_reset();
        run(3);
        total++; if (freq_out !== '0) begin bad++; $display("FAIL reset_freq: got %h want 0", freq_out); end
        total++; if (sat_out !== '0) begin bad++; $display("FAIL reset_sat: got %b want 0", sat_out); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (freq_out4 !== '0) begin bad++; $display("FAIL reset_freq4: got %h want 0", freq_out4); end
        rst = 1'b0;
        run(10);
    endtask

    task automatic test_rising();
        int e, n;
        logic [CH*FW-1:0] fv;
        clear_q();
        edge_mode = 2'b00;
        set_gen(0, 1, 10);
        for (int ch = 1; ch < CH; ch++) set_gen(ch, 1, int'($urandom_range(60, 4)));
        run(20);
        enable = 1'b1;
        e = cyc;
        run(50);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rising_busy_open: got %b want 1", busy); end
        run(255);
        enable = 1'b0;
        run(5);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rising_busy_idle: got %b want 0", busy); end
        total++; if (vq_cyc.size() !== 3) begin bad++; $display("FAIL rising_valid_count: got %0d want 3", vq_cyc.size()); end
        for (int k = 0; k < vq_cyc.size(); k++) begin
            fv = vq_f[k];
            total++; if (vq_cyc[k] !== e + 101 + 100 * k) begin bad++; $display("FAIL rising_valid_time k=%0d: got %0d want %0d", k, vq_cyc[k], e + 101 + 100 * k); end
            total++; if (fv[FW-1:0] !== 32'd10000) begin bad++; $display("FAIL rising_ch0 k=%0d: got %0d want 10000", k, fv[FW-1:0]); end
            for (int ch = 0; ch < CH; ch++) begin
                n = exp_count(ch, vq_cyc[k] - GATE);
                total++; if (fv[ch*FW +: FW] !== exp_freq(n, 20)) begin bad++; $display("FAIL rising_model k=%0d ch=%0d: got %0d want %0d", k, ch, fv[ch*FW +: FW], exp_freq(n, 20)); end
            end
            total++; if (vq_s[k] !== '0) begin bad++; $display("FAIL rising_sat k=%0d: got %b want 0", k, vq_s[k]); end
        end
    endtask

    task automatic test_mode_switch();
        int e, n;
        logic [CH*FW-1:0] fv;
        logic [31:0] want0;
        clear_q();
        edge_mode = 2'b10;
        set_gen(0, 1, 10);
        for (int ch = 1; ch < CH; ch++) set_gen(ch, 1, int'($urandom_range(40, 4)));
        run(10);
        enable = 1'b1;
        e = cyc;
        while (cyc < e + 51) tick();
        edge_mode = 2'b01;
        while (cyc < e + 305) tick();
        enable = 1'b0;
        run(5);
        total++; if (vq_cyc.size() !== 3) begin bad++; $display("FAIL mode_valid_count: got %0d want 3", vq_cyc.size()); end
        for (int k = 0; k < vq_cyc.size(); k++) begin
            fv = vq_f[k];
            want0 = (k == 0) ? 32'd20000 : 32'd10000;
            total++; if (fv[FW-1:0] !== want0) begin bad++; $display("FAIL mode_ch0 k=%0d: got %0d want %0d", k, fv[FW-1:0], want0); end
            for (int ch = 0; ch < CH; ch++) begin
                n = exp_count(ch, vq_cyc[k] - GATE);
                total++; if (fv[ch*FW +: FW] !== exp_freq(n, 20)) begin bad++; $display("FAIL mode_model k=%0d ch=%0d: got %0d want %0d", k, ch, fv[ch*FW +: FW], exp_freq(n, 20)); end
            end
        end
    endtask

    task automatic test_saturation();
        int e, n;
        logic [CH*FW-1:0] fv, fv4;
        logic [CH-1:0] s4;
        clear_q();
        edge_mode = 2'b00;
        set_gen(0, 1, 10);
        set_gen(1, 1, 5);
        set_gen(2, 1, 20);
        set_gen(3, 2, 2);
        run(10);
        enable = 1'b1;
        e = cyc;
        run(205);
        enable = 1'b0;
        run(5);
        total++; if (vq_cyc.size() !== 2) begin bad++; $display("FAIL sat_valid_count: got %0d want 2", vq_cyc.size()); end
        for (int k = 0; k < vq_cyc.size(); k++) begin
            fv = vq_f[k];
            fv4 = vq_f4[k];
            s4 = vq_s4[k];
            total++; if (fv4[FW +: FW] !== 32'd15000) begin bad++; $display("FAIL sat_ch1_freq4 k=%0d: got %0d want 15000", k, fv4[FW +: FW]); end
            total++; if (s4[1] !== 1'b1) begin bad++; $display("FAIL sat_ch1_flag4 k=%0d: got %b want 1", k, s4[1]); end
            total++; if (s4[0] !== 1'b0) begin bad++; $display("FAIL sat_ch0_flag4 k=%0d: got %b want 0", k, s4[0]); end
            total++; if (fv[FW +: FW] !== 32'd20000) begin bad++; $display("FAIL sat_ch1_wide k=%0d: got %0d want 20000", k, fv[FW +: FW]); end
            for (int ch = 0; ch < CH; ch++) begin
                n = exp_count(ch, vq_cyc[k] - GATE);
                total++; if (fv4[ch*FW +: FW] !== exp_freq(n, 4)) begin bad++; $display("FAIL sat_model4 k=%0d ch=%0d: got %0d want %0d", k, ch, fv4[ch*FW +: FW], exp_freq(n, 4)); end
                total++; if (s4[ch] !== exp_sat(n, 4)) begin bad++; $display("FAIL sat_flag_model4 k=%0d ch=%0d: got %b want %b", k, ch, s4[ch], exp_sat(n, 4)); end
            end
            total++; if (vq_s[k] !== '0) begin bad++; $display("FAIL sat_wide_flags k=%0d: got %b want 0", k, vq_s[k]); end
        end
    endtask

    task automatic test_abort();
        int e, e2, n;
        logic [CH*FW-1:0] hold_f, fv;
        logic [CH-1:0] hold_s;
        clear_q();
        edge_mode = 2'b00;
        for (int ch = 0; ch < CH; ch++) set_gen(ch, 1, int'($urandom_range(50, 4)));
        run(10);
        enable = 1'b1;
        e = cyc;
        while (cyc < e + 151) tick();
        enable = 1'b0;
        hold_f = freq_out;
        hold_s = sat_out;
        run(150);
        total++; if (vq_cyc.size() !== 1) begin bad++; $display("FAIL abort_valid_count: got %0d want 1", vq_cyc.size()); end
        total++; if (freq_out !== hold_f) begin bad++; $display("FAIL abort_freq_hold: got %h want %h", freq_out, hold_f); end
        total++; if (sat_out !== hold_s) begin bad++; $display("FAIL abort_sat_hold: got %b want %b", sat_out, hold_s); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        clear_q();
        enable = 1'b1;
        e2 = cyc;
        run(110);
        enable = 1'b0;
        run(3);
        total++; if (vq_cyc.size() !== 1) begin bad++; $display("FAIL reenable_valid_count: got %0d want 1", vq_cyc.size()); end
        if (vq_cyc.size() > 0) begin
            fv = vq_f[0];
            total++; if (vq_cyc[0] !== e2 + 101) begin bad++; $display("FAIL reenable_latency: got %0d want %0d", vq_cyc[0] - e2, 101); end
            for (int ch = 0; ch < CH; ch++) begin
                n = exp_count(ch, vq_cyc[0] - GATE);
                total++; if (fv[ch*FW +: FW] !== exp_freq(n, 20)) begin bad++; $display("FAIL reenable_model ch=%0d: got %0d want %0d", ch, fv[ch*FW +: FW], exp_freq(n, 20)); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int e, r;
        logic [CH*FW-1:0] fv;
        clear_q();
        edge_mode = 2'b10;
        for (int ch = 0; ch < CH; ch++) set_gen(ch, 2, 2);
        run(5);
        enable = 1'b1;
        e = cyc;
        while (cyc < e + 141) tick();
        total++; if (vq_cyc.size() !== 1) begin bad++; $display("FAIL rstmid_prewindow: got %0d want 1", vq_cyc.size()); end
        rst = 1'b1;
        tick();
        total++; if (freq_out !== '0) begin bad++; $display("FAIL rstmid_freq: got %h want 0", freq_out); end
        total++; if (sat_out !== '0) begin bad++; $display("FAIL rstmid_sat: got %b want 0", sat_out); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        hold_bits = '1;
        for (int ch = 0; ch < CH; ch++) gen_kind[ch] = 0;
        run(5);
        rst = 1'b0;
        r = cyc;
        clear_q();
        run(106);
        enable = 1'b0;
        run(3);
        total++; if (vq_cyc.size() !== 1) begin bad++; $display("FAIL rsthigh_valid_count: got %0d want 1", vq_cyc.size()); end
        if (vq_cyc.size() > 0) begin
            fv = vq_f[0];
            total++; if (vq_cyc[0] !== r + 101) begin bad++; $display("FAIL rsthigh_latency: got %0d want %0d", vq_cyc[0], r + 101); end
            for (int ch = 0; ch < CH; ch++) begin
                total++; if (fv[ch*FW +: FW] !== 32'd0) begin bad++; $display("FAIL rsthigh_count ch=%0d: got %0d want 0", ch, fv[ch*FW +: FW]); end
            end
        end
    endtask

    task automatic test_multi();
        int e, n;
        int per [CH];
        logic [CH*FW-1:0] fv;
        per = '{4, 10, 25, 50};
        clear_q();
        edge_mode = 2'b00;
        for (int ch = 0; ch < CH; ch++) set_gen(ch, 1, per[ch]);
        run(10);
        enable = 1'b1;
        e = cyc;
        run(205);
        enable = 1'b0;
        run(3);
        total++; if (vq_cyc.size() !== 2) begin bad++; $display("FAIL multi_valid_count: got %0d want 2", vq_cyc.size()); end
        for (int k = 0; k < vq_cyc.size(); k++) begin
            fv = vq_f[k];
            for (int ch = 0; ch < CH; ch++) begin
                n = exp_count(ch, vq_cyc[k] - GATE);
                total++; if (fv[ch*FW +: FW] !== 32'((100 / per[ch]) * SCALE)) begin bad++; $display("FAIL multi_const k=%0d ch=%0d: got %0d want %0d", k, ch, fv[ch*FW +: FW], (100 / per[ch]) * SCALE); end
                total++; if (fv[ch*FW +: FW] !== exp_freq(n, 20)) begin bad++; $display("FAIL multi_model k=%0d ch=%0d: got %0d want %0d", k, ch, fv[ch*FW +: FW], exp_freq(n, 20)); end
            end
        end
    endtask

    task automatic test_window_edge();
        int e, f, nc;
        int want [2][CH];
        logic [CH*FW-1:0] fv;
        want = '{'{1000, 0, 1000, 0}, '{0, 1000, 0, 0}};
        clear_q();
        edge_mode = 2'b00;
        hold_bits = '0;
        for (int ch = 0; ch < CH; ch++) gen_kind[ch] = 0;
        run(10);
        e = cyc + 10;
        f = e + 1;
        while (cyc < f + 205) begin
            nc = cyc + 1;
            if (nc == f - 1 - SYNC) hold_bits[3] = 1'b1;
            if (nc == f - SYNC) hold_bits[2] = 1'b1;
            if (nc == f + 99 - SYNC) hold_bits[0] = 1'b1;
            if (nc == f + 100 - SYNC) hold_bits[1] = 1'b1;
            tick();
            if (cyc == e) enable = 1'b1;
        end
        enable = 1'b0;
        run(3);
        total++; if (vq_cyc.size() !== 2) begin bad++; $display("FAIL edge_valid_count: got %0d want 2", vq_cyc.size()); end
        for (int k = 0; k < vq_cyc.size() && k < 2; k++) begin
            fv = vq_f[k];
            for (int ch = 0; ch < CH; ch++) begin
                total++; if (fv[ch*FW +: FW] !== 32'(want[k][ch])) begin bad++; $display("FAIL edge_boundary k=%0d ch=%0d: got %0d want %0d", k, ch, fv[ch*FW +: FW], want[k][ch]); end
            end
        end
    endtask

    task automatic test_random();
        int e, n;
        logic [CH*FW-1:0] fv, fv4;
        clear_q();
        dbl_cnt = 0;
        edge_mode = 2'($urandom_range(3));
        for (int ch = 0; ch < CH; ch++) begin
            if ($urandom_range(1) == 0) set_gen(ch, 1, int'($urandom_range(30, 2)));
            else set_gen(ch, 2, 2);
        end
        run(10);
        enable = 1'b1;
        e = cyc;
        for (int j = 0; j < 405; j++) begin
            if ($urandom_range(36) == 0) edge_mode = 2'($urandom_range(3));
            tick();
        end
        enable = 1'b0;
        run(3);
        total++; if (vq_cyc.size() !== 4) begin bad++; $display("FAIL random_valid_count: got %0d want 4", vq_cyc.size()); end
        total++; if (dbl_cnt !== 0) begin bad++; $display("FAIL random_valid_double: got %0d want 0", dbl_cnt); end
        for (int k = 0; k < vq_cyc.size(); k++) begin
            fv = vq_f[k];
            fv4 = vq_f4[k];
            total++; if (vq_cyc[k] !== e + 101 + 100 * k) begin bad++; $display("FAIL random_valid_time k=%0d: got %0d want %0d", k, vq_cyc[k], e + 101 + 100 * k); end
            for (int ch = 0; ch < CH; ch++) begin
                n = exp_count(ch, vq_cyc[k] - GATE);
                total++; if (fv[ch*FW +: FW] !== exp_freq(n, 20)) begin bad++; $display("FAIL random_model k=%0d ch=%0d: got %0d want %0d", k, ch, fv[ch*FW +: FW], exp_freq(n, 20)); end
                total++; if (fv4[ch*FW +: FW] !== exp_freq(n, 4)) begin bad++; $display("FAIL random_model4 k=%0d ch=%0d: got %0d want %0d", k, ch, fv4[ch*FW +: FW], exp_freq(n, 4)); end
                total++; if (vq_s4[k][ch] !== exp_sat(n, 4)) begin bad++; $display("FAIL random_sat4 k=%0d ch=%0d: got %b want %b", k, ch, vq_s4[k][ch], exp_sat(n, 4)); end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sig = '0;
        hold_bits = '0;
        for (int ch = 0; ch < CH; ch++) begin
            gen_kind[ch] = 0;
            period[ch] = 2;
            phase[ch] = 0;
        end
        sig_rec[0] = '0;
        test_reset();
        test_rising();
        test_mode_switch();
        test_saturation();
        test_abort();
        test_reset_mid();
        test_multi();
        test_window_edge();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
